// File: rtl/gs_epoch_averager_pkg.sv
// Shared constants, state encoding and RMW pipeline record for the epoch averager.
package gs_epoch_averager_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 8;
    localparam int KMAX     = 10;
    localparam int ACC_W    = SAMPLE_W + KMAX;
    localparam int CNT_W    = KMAX + 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARMED = 2'd1;
    localparam state_t ST_ACQ   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // One in-flight read-modify-write: the sample waits here while the RAM read completes.
    typedef struct packed {
        logic                       valid;
        logic                       first;
        logic [ADDR_W-1:0]          addr;
        logic signed [SAMPLE_W-1:0] sample;
    } rmw_t;

    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        return (k > 4'(KMAX)) ? 4'(KMAX) : k;
    endfunction

endpackage

// File: rtl/gs_epoch_averager_if.sv
// Control, acquisition and readback signals between the averager and its host.
interface gs_epoch_averager_if;
    import gs_epoch_averager_pkg::*;

    logic                start;
    logic [3:0]          epoch_log2;
    logic                stim_trig;
    logic                adc_valid;
    logic [SAMPLE_W-1:0] adc_sample;
    logic [ADDR_W-1:0]   addr;
    logic                raw_data_ready;
    logic [SAMPLE_W-1:0] avg_sample;
    logic                busy;
    logic [CNT_W-1:0]    epoch_count;
    logic                trig_missed;

    modport master (
        output start, epoch_log2, stim_trig, adc_valid, adc_sample, addr,
        input  raw_data_ready, avg_sample, busy, epoch_count, trig_missed
    );

    modport slave (
        input  start, epoch_log2, stim_trig, adc_valid, adc_sample, addr,
        output raw_data_ready, avg_sample, busy, epoch_count, trig_missed
    );

endinterface

// File: rtl/gs_epoch_averager_acc_ram.sv
// 256 x ACC_W simple dual-port accumulator RAM with a registered read port.
module gs_epoch_averager_acc_ram
    import gs_epoch_averager_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data
);

    logic [ACC_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ACC_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/gs_epoch_averager.sv
// Coherent averager: accumulates 2^K triggered epochs of 256 samples, then
// serves the averaged waveform through a 1-cycle-latency read port.
module gs_epoch_averager
    import gs_epoch_averager_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    gs_epoch_averager_if.slave bus
);

    state_t            state_reg;
    logic [3:0]        k_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              trig_missed_reg;
    logic              fin_reg;
    rmw_t              rmw_reg;

    logic              acq_live;
    logic              strobe;
    logic              last_sample;
    logic              last_epoch;
    logic [CNT_W-1:0]  target;
    logic [ACC_W-1:0]  rd_data;
    logic [ACC_W-1:0]  wr_data;
    logic [ACC_W-1:0]  sample_ext;
    logic [ADDR_W-1:0] rd_addr;

    // fin_reg marks the drain window after the final sample: acquisition has
    // stopped but the last write is still landing.
    assign acq_live    = (state_reg == ST_ACQ) && !fin_reg;
    assign strobe      = acq_live && bus.adc_valid;
    assign last_sample = (idx_reg == '1);
    assign target      = CNT_W'(1) << k_reg;
    assign last_epoch  = ((count_reg + CNT_W'(1)) == target);

    assign sample_ext = {{KMAX{rmw_reg.sample[SAMPLE_W-1]}}, rmw_reg.sample};
    assign wr_data    = rmw_reg.first ? sample_ext : (rd_data + sample_ext);
    assign rd_addr    = acq_live ? idx_reg : bus.addr;

    gs_epoch_averager_acc_ram u_acc_ram (
        .clk     (clk),
        .wr_en   (rmw_reg.valid),
        .wr_addr (rmw_reg.addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            k_reg           <= '0;
            count_reg       <= '0;
            idx_reg         <= '0;
            trig_missed_reg <= 1'b0;
            fin_reg         <= 1'b0;
            rmw_reg         <= '0;
        end else begin
            rmw_reg.valid  <= strobe;
            rmw_reg.first  <= (count_reg == '0);
            rmw_reg.addr   <= idx_reg;
            rmw_reg.sample <= bus.adc_sample;

            if (bus.start) begin
                state_reg       <= ST_ARMED;
                k_reg           <= clamp_k(bus.epoch_log2);
                count_reg       <= '0;
                trig_missed_reg <= 1'b0;
                fin_reg         <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ARMED: begin
                        if (bus.stim_trig) begin
                            state_reg <= ST_ACQ;
                            idx_reg   <= '0;
                        end
                    end
                    ST_ACQ: begin
                        if (bus.stim_trig) begin
                            trig_missed_reg <= 1'b1;
                        end
                        if (fin_reg) begin
                            // Enter DONE only once the final write has committed.
                            if (!rmw_reg.valid) begin
                                state_reg <= ST_DONE;
                                fin_reg   <= 1'b0;
                            end
                        end else if (strobe) begin
                            idx_reg <= idx_reg + ADDR_W'(1);
                            if (last_sample) begin
                                count_reg <= count_reg + CNT_W'(1);
                                if (last_epoch) begin
                                    fin_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_ARMED;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.raw_data_ready = (state_reg == ST_DONE);
    assign bus.busy           = (state_reg == ST_ARMED) || (state_reg == ST_ACQ);
    assign bus.epoch_count    = count_reg;
    assign bus.trig_missed    = trig_missed_reg;
    assign bus.avg_sample     = (state_reg == ST_DONE)
                              ? SAMPLE_W'($signed(rd_data) >>> k_reg) : '0;

endmodule

// File: tb/tb_gs_epoch_averager.sv
// Directed + randomized bench for gs_epoch_averager against a sum-and-divide model.
module tb_gs_epoch_averager;
    import gs_epoch_averager_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gs_epoch_averager_if bus();

    gs_epoch_averager dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int model_sum [256];
    int model_k;
    int model_count;
    int ep [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_start(input int k);
        model_k     = (k > KMAX) ? KMAX : k;
        model_count = 0;
        for (int i = 0; i < 256; i++) model_sum[i] = 0;
    endtask

    task automatic do_start(input int k);
        bus.start      = 1'b1;
        bus.epoch_log2 = 4'(k);
        tick();
        bus.start = 1'b0;
        m_start(k);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 256; n++) ep[n] = int'($signed(16'($urandom)));
    endtask

    task automatic fill_const(input int v);
        for (int n = 0; n < 256; n++) ep[n] = v;
    endtask

    // One full epoch of ep[]; optional idle gaps and an extra trigger at sample miss_at.
    task automatic run_epoch(input bit gaps, input int miss_at);
        bus.stim_trig = 1'b1;
        tick();
        bus.stim_trig = 1'b0;
        for (int n = 0; n < 256; n++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.adc_valid  = 1'b0;
                bus.adc_sample = 16'($urandom);
                tick();
            end
            bus.adc_valid  = 1'b1;
            bus.adc_sample = 16'(ep[n]);
            bus.stim_trig  = (n == miss_at);
            tick();
            model_sum[n] += ep[n];
        end
        bus.adc_valid = 1'b0;
        bus.stim_trig = 1'b0;
        model_count++;
    endtask

    task automatic run_partial(input int count);
        bus.stim_trig = 1'b1;
        tick();
        bus.stim_trig = 1'b0;
        for (int n = 0; n < count; n++) begin
            bus.adc_valid  = 1'b1;
            bus.adc_sample = 16'($urandom);
            tick();
        end
        bus.adc_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !bus.raw_data_ready; i++) tick();
        check(tag, 32'(bus.raw_data_ready), 1);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 32'(bus.epoch_count), model_count);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        for (int a = 0; a < 256; a++) begin
            bus.addr = 8'(a);
            tick();
            check($sformatf("%s_addr%0d", tag, a), 32'($signed(bus.avg_sample)), model_sum[a] >>> model_k);
        end
    endtask

    initial begin
        bus.start = 0; bus.epoch_log2 = 0; bus.stim_trig = 0;
        bus.adc_valid = 0; bus.adc_sample = 0; bus.addr = 0;
        tick(); tick();
        check("rst_ready", 32'(bus.raw_data_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_count", 32'(bus.epoch_count), 0);
        check("rst_missed", 32'(bus.trig_missed), 0);
        check("rst_avg", 32'(bus.avg_sample), 0);
        rst_n = 1'b1;
        tick();

        // K=0 ramp: output equals raw samples
        do_start(0);
        check("t1_busy", 32'(bus.busy), 1);
        for (int n = 0; n < 256; n++) ep[n] = n - 128;
        run_epoch(1'b1, -1);
        wait_done("t1_done");
        bus.addr = 8'd5;
        tick();
        check("t1_addr5", 32'($signed(bus.avg_sample)), -123);
        check_all("t1");

        // K=2, constants 100..400 average to 250
        do_start(2);
        check("t2_ready_clr", 32'(bus.raw_data_ready), 0);
        for (int e = 0; e < 4; e++) begin
            fill_const(100 * (e + 1));
            run_epoch(1'b1, -1);
        end
        wait_done("t2_done");
        bus.addr = 8'd17;
        tick();
        check("t2_addr17", 32'($signed(bus.avg_sample)), 250);
        check_all("t2");

        // K=1, back-to-back strobes with random data
        do_start(1);
        for (int e = 0; e < 2; e++) begin
            fill_random();
            run_epoch(1'b0, -1);
        end
        wait_done("t4_done");
        check_all("t4");

        // Extra trigger mid-ACQ is flagged but does not disturb the epoch
        do_start(1);
        fill_random();
        run_epoch(1'b0, 100);
        check("t5_missed", 32'(bus.trig_missed), 1);
        fill_random();
        run_epoch(1'b1, -1);
        wait_done("t5_done");
        check("t5_missed_hold", 32'(bus.trig_missed), 1);
        check_all("t5");

        // Start and trigger together: start wins, trigger not taken
        bus.start = 1'b1; bus.stim_trig = 1'b1; bus.epoch_log2 = 4'd0;
        tick();
        bus.start = 1'b0; bus.stim_trig = 1'b0;
        m_start(0);
        check("t5_missed_clr", 32'(bus.trig_missed), 0);
        check("t5b_busy", 32'(bus.busy), 1);
        for (int n = 0; n < 256; n++) begin
            bus.adc_valid = 1'b1; bus.adc_sample = 16'($urandom);
            tick();
        end
        bus.adc_valid = 1'b0;
        check("t5b_not_done", 32'(bus.raw_data_ready), 0);
        fill_random();
        run_epoch(1'b1, -1);
        wait_done("t5b_done");
        check_all("t5b");

        // Asynchronous reset mid-ACQ, then an abort halfway through epoch 3
        do_start(2);
        bus.stim_trig = 1'b1;
        tick();
        bus.stim_trig = 1'b1;
        tick();
        bus.stim_trig = 1'b0;
        check("t6_pre_missed", 32'(bus.trig_missed), 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_missed", 32'(bus.trig_missed), 0);
        check("t6_rst_avg", 32'(bus.avg_sample), 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(2);
        for (int e = 0; e < 2; e++) begin
            fill_random();
            run_epoch(1'b0, -1);
        end
        check("t6_count2", 32'(bus.epoch_count), 2);
        run_partial(128);
        do_start(2);
        check("t6_count_clr", 32'(bus.epoch_count), 0);
        for (int e = 0; e < 4; e++) begin
            fill_random();
            run_epoch(1'b1, -1);
        end
        wait_done("t6_done");
        check_all("t6");

        // Full-scale negative and positive accumulation
        do_start(6);
        fill_const(-32768);
        for (int e = 0; e < 64; e++) run_epoch(1'b0, -1);
        wait_done("t3_done");
        check_all("t3");
        do_start(3);
        fill_const(32767);
        for (int e = 0; e < 8; e++) run_epoch(1'b0, -1);
        wait_done("t3p_done");
        check_all("t3p");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
